// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported RAM between instruction fetch and the data (load/store) path.
// Latency : request sampled in IDLE at cycle N -> ram_en at N+1 -> ack at N+2+RAM_LAT.
// Backpr. : requesters hold their request until acked; stall is high while any request is unacked.
//
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   i_req/i_addr                fetch request and address, held until i_ack
//   i_ack/i_rdata               one-cycle fetch done pulse, registered instruction word
//   d_rd/d_wr/d_addr/d_wdata    data read/write request, address and store data, held until d_ack
//   d_ack/d_rdata               one-cycle data done pulse, registered load data (read acks only)
//   ram_en/ram_we/ram_addr/
//   ram_wdata/ram_rdata         RAM strobe, write enable, address, write data, read data
//   stall                       combinational stall to the core
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RAM_LAT = 1    // legal range 1..15 (counter is 4 bits)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ack,
    output logic [DW-1:0] i_rdata,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          stall
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    typedef enum logic {
        GR_FETCH = 1'b0,
        GR_DATA  = 1'b1
    } grant_t;

    localparam logic [3:0] LP_CNT_LOAD = 4'(RAM_LAT - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_cnt;
    // Doubles as the owner of the in-flight access: it is updated on every grant.
    grant_t        r_last_grant;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;

    logic          w_d_req;
    logic          w_grant_f;
    logic          w_grant_d;
    logic          w_capture;

    assign w_d_req = d_rd | d_wr;

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant_f   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Data wins only if fetch is idle or fetch was served last;
                // with reset value DATA this makes fetch win the first tie.
                if (w_d_req && (!i_req || r_last_grant == GR_FETCH)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else if (i_req) begin
                    w_grant_f   = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_ACK;
                end
            end
            // Requests are deliberately not looked at here, so a request that
            // is still high after its ack is only seen again in IDLE.
            ST_ACK:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Read data is valid in the last WAIT cycle; writes never capture.
    assign w_capture = (r_state == ST_WAIT) && (r_cnt == 4'd0) && !r_ram_we;

    // ------------------------------------------------------------------
    // State, counter and grant registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (r_state == ST_ISSUE) begin
            r_cnt <= LP_CNT_LOAD;
        end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GR_DATA;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
        end else if (w_grant_d) begin
            // d_rd and d_wr together count as a write.
            r_last_grant <= GR_DATA;
            r_ram_we     <= d_wr;
            r_ram_addr   <= d_addr;
            r_ram_wdata  <= d_wdata;
        end else if (w_grant_f) begin
            r_last_grant <= GR_FETCH;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= i_addr;
            r_ram_wdata  <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Read data return
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else if (w_capture) begin
            if (r_last_grant == GR_FETCH) begin
                r_i_rdata <= ram_rdata;
            end else begin
                r_d_rdata <= ram_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ram_en    = (r_state == ST_ISSUE);
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign i_ack     = (r_state == ST_ACK) && (r_last_grant == GR_FETCH);
    assign d_ack     = (r_state == ST_ACK) && (r_last_grant == GR_DATA);
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

    // Gated with rst_n so every output reads 0 while reset is held, even if
    // a requester keeps its request raised.
    assign stall = rst_n & ((i_req & ~i_ack) | (w_d_req & ~d_ack));

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam logic [31:0] MAGIC = 32'h2008_0045;
    localparam logic [3:0]  LAT1  = 4'd1;
    localparam logic [3:0]  LAT4  = 4'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_rd = 1'b0;
    logic        d_wr = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;

    logic        i_ack1, d_ack1, ram_en1, ram_we1, stall1;
    logic [31:0] i_rdata1, d_rdata1, ram_addr1, ram_wdata1, ram_rdata1;
    logic        i_ack4, d_ack4, ram_en4, ram_we4, stall4;
    logic [31:0] i_rdata4, d_rdata4, ram_addr4, ram_wdata4, ram_rdata4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack1), .i_rdata(i_rdata1),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack1), .d_rdata(d_rdata1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1), .stall(stall1)
    );

    mem_port_arbiter #(.AW(32), .DW(32), .RAM_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack4), .i_rdata(i_rdata4),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack4), .d_rdata(d_rdata4),
        .ram_en(ram_en4), .ram_we(ram_we4), .ram_addr(ram_addr4),
        .ram_wdata(ram_wdata4), .ram_rdata(ram_rdata4), .stall(stall4)
    );

    // RAM models: read data is addr^MAGIC only in the single cycle RAM_LAT
    // cycles after ram_en; every other cycle carries a poison pattern.
    logic [3:0]  k1, k4;
    logic [31:0] a1, a4;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k1 <= 4'd0; a1 <= '0;
        end else if (ram_en1) begin
            k1 <= 4'd1; a1 <= ram_addr1;
        end else if (k1 != 4'd0 && k1 < LAT1) begin
            k1 <= k1 + 4'd1;
        end else begin
            k1 <= 4'd0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k4 <= 4'd0; a4 <= '0;
        end else if (ram_en4) begin
            k4 <= 4'd1; a4 <= ram_addr4;
        end else if (k4 != 4'd0 && k4 < LAT4) begin
            k4 <= k4 + 4'd1;
        end else begin
            k4 <= 4'd0;
        end
    end

    assign ram_rdata1 = (k1 == LAT1) ? (a1 ^ MAGIC) : 32'hBAD0_BAD0;
    assign ram_rdata4 = (k4 == LAT4) ? (a4 ^ MAGIC) : 32'hBAD0_BAD0;

    task automatic do_reset();
        rst_n = 1'b0;
        i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        i_req = 1'b1; d_rd = 1'b1; d_wr = 1'b1;
        i_addr = 32'h40; d_addr = 32'h80; d_wdata = 32'h5555_AAAA;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({i_ack1, d_ack1, ram_en1, ram_we1, stall1} !== 5'b0) begin
            n_bad++; $display("FAIL rst_ctl1 got=%b exp=00000", {i_ack1, d_ack1, ram_en1, ram_we1, stall1});
        end
        n_cmp++;
        if ({i_rdata1, d_rdata1, ram_addr1, ram_wdata1} !== 128'b0) begin
            n_bad++; $display("FAIL rst_dat1 got=%h exp=0", {i_rdata1, d_rdata1, ram_addr1, ram_wdata1});
        end
        n_cmp++;
        if ({i_ack4, d_ack4, ram_en4, ram_we4, stall4} !== 5'b0) begin
            n_bad++; $display("FAIL rst_ctl4 got=%b exp=00000", {i_ack4, d_ack4, ram_en4, ram_we4, stall4});
        end
        n_cmp++;
        if ({i_rdata4, d_rdata4, ram_addr4, ram_wdata4} !== 128'b0) begin
            n_bad++; $display("FAIL rst_dat4 got=%h exp=0", {i_rdata4, d_rdata4, ram_addr4, ram_wdata4});
        end
    endtask

    task automatic test_fetch_lat1();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_req = (c < 4); i_addr = 32'h40;
            #1;
            n_cmp++;
            if (ram_en1 !== (c == 1)) begin
                n_bad++; $display("FAIL t1_ram_en c=%0d got=%b exp=%b", c, ram_en1, c == 1);
            end
            n_cmp++;
            if (i_ack1 !== (c == 3)) begin
                n_bad++; $display("FAIL t1_i_ack c=%0d got=%b exp=%b", c, i_ack1, c == 3);
            end
            n_cmp++;
            if (stall1 !== (c < 3)) begin
                n_bad++; $display("FAIL t1_stall c=%0d got=%b exp=%b", c, stall1, c < 3);
            end
            if (c == 1) begin
                n_cmp++;
                if (ram_addr1 !== 32'h40 || ram_we1 !== 1'b0) begin
                    n_bad++; $display("FAIL t1_ram_addr got=%h we=%b exp=00000040 we=0", ram_addr1, ram_we1);
                end
            end
            if (c >= 3) begin
                n_cmp++;
                if (i_rdata1 !== 32'h2008_0005) begin
                    n_bad++; $display("FAIL t1_i_rdata c=%0d got=%h exp=20080005", c, i_rdata1);
                end
            end
        end
    endtask

    task automatic test_tie_after_reset();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            i_req = (c < 4); d_rd = (c < 8);
            i_addr = 32'h40; d_addr = 32'h80;
            #1;
            n_cmp++;
            if (ram_en1 !== (c == 1 || c == 5)) begin
                n_bad++; $display("FAIL t2_ram_en c=%0d got=%b exp=%b", c, ram_en1, c == 1 || c == 5);
            end
            n_cmp++;
            if (i_ack1 !== (c == 3) || d_ack1 !== (c == 7)) begin
                n_bad++; $display("FAIL t2_acks c=%0d got=%b%b exp=%b%b", c, i_ack1, d_ack1, c == 3, c == 7);
            end
            n_cmp++;
            if (stall1 !== (c < 7)) begin
                n_bad++; $display("FAIL t2_stall c=%0d got=%b exp=%b", c, stall1, c < 7);
            end
            if (c == 5) begin
                n_cmp++;
                if (ram_addr1 !== 32'h80) begin
                    n_bad++; $display("FAIL t2_ram_addr got=%h exp=00000080", ram_addr1);
                end
            end
            if (c == 7) begin
                n_cmp++;
                if (d_rdata1 !== 32'h2008_00C5 || i_rdata1 !== 32'h2008_0005) begin
                    n_bad++; $display("FAIL t2_rdata got=%h/%h exp=200800c5/20080005", d_rdata1, i_rdata1);
                end
            end
        end
    endtask

    // Runs straight after test_tie_after_reset so the read data registers
    // hold known non-zero values that a write must not disturb.
    task automatic test_write();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            i_req = 1'b0; d_rd = 1'b0; d_wr = (c < 4);
            d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
            #1;
            n_cmp++;
            if (ram_en1 !== (c == 1)) begin
                n_bad++; $display("FAIL t3_ram_en c=%0d got=%b exp=%b", c, ram_en1, c == 1);
            end
            n_cmp++;
            if (d_ack1 !== (c == 3)) begin
                n_bad++; $display("FAIL t3_d_ack c=%0d got=%b exp=%b", c, d_ack1, c == 3);
            end
            if (c == 1) begin
                n_cmp++;
                if (ram_we1 !== 1'b1 || ram_addr1 !== 32'h100 || ram_wdata1 !== 32'hDEAD_BEEF) begin
                    n_bad++; $display("FAIL t3_wr_port got we=%b a=%h d=%h exp we=1 a=00000100 d=deadbeef", ram_we1, ram_addr1, ram_wdata1);
                end
            end
            if (c >= 3) begin
                n_cmp++;
                if (d_rdata1 !== 32'h2008_00C5 || i_rdata1 !== 32'h2008_0005) begin
                    n_bad++; $display("FAIL t3_rdata_kept c=%0d got=%h/%h exp=200800c5/20080005", c, d_rdata1, i_rdata1);
                end
            end
        end
    endtask

    task automatic test_lat4();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            i_req = (c < 7); i_addr = 32'h44;
            #1;
            n_cmp++;
            if (ram_en4 !== (c == 1)) begin
                n_bad++; $display("FAIL t4_ram_en c=%0d got=%b exp=%b", c, ram_en4, c == 1);
            end
            n_cmp++;
            if (i_ack4 !== (c == 6)) begin
                n_bad++; $display("FAIL t4_i_ack c=%0d got=%b exp=%b", c, i_ack4, c == 6);
            end
            n_cmp++;
            if (i_rdata4 !== ((c >= 6) ? 32'h2008_0001 : 32'h0)) begin
                n_bad++; $display("FAIL t4_i_rdata c=%0d got=%h exp=%h", c, i_rdata4, (c >= 6) ? 32'h2008_0001 : 32'h0);
            end
            n_cmp++;
            if (stall4 !== (c < 6)) begin
                n_bad++; $display("FAIL t4_stall c=%0d got=%b exp=%b", c, stall4, c < 6);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            i_req = 1'b1; i_addr = 32'h48;
            if (c == 3) rst_n = 1'b0;
        end
        #1;
        n_cmp++;
        if ({i_ack4, d_ack4, ram_en4, ram_we4, stall4} !== 5'b0) begin
            n_bad++; $display("FAIL t5_ctl_in_rst got=%b exp=00000", {i_ack4, d_ack4, ram_en4, ram_we4, stall4});
        end
        n_cmp++;
        if (ram_addr4 !== 32'h0 || i_rdata4 !== 32'h0) begin
            n_bad++; $display("FAIL t5_dat_in_rst got a=%h d=%h exp 0/0", ram_addr4, i_rdata4);
        end
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            i_req = (c >= 2 && c < 9); i_addr = 32'h48;
            #1;
            n_cmp++;
            if (i_ack4 !== (c == 8)) begin
                n_bad++; $display("FAIL t5_i_ack c=%0d got=%b exp=%b", c, i_ack4, c == 8);
            end
            n_cmp++;
            if (ram_en4 !== (c == 3)) begin
                n_bad++; $display("FAIL t5_ram_en c=%0d got=%b exp=%b", c, ram_en4, c == 3);
            end
            if (c == 8) begin
                n_cmp++;
                if (i_rdata4 !== 32'h2008_000D) begin
                    n_bad++; $display("FAIL t5_i_rdata got=%h exp=2008000d", i_rdata4);
                end
            end
        end
    endtask

    task automatic test_rd_wr_both();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            d_rd = (c < 4); d_wr = (c < 4);
            d_addr = 32'h100; d_wdata = 32'h1234_5678;
            #1;
            if (c == 1) begin
                n_cmp++;
                if (ram_en1 !== 1'b1 || ram_we1 !== 1'b1 || ram_wdata1 !== 32'h1234_5678) begin
                    n_bad++; $display("FAIL t6_both_wr got en=%b we=%b d=%h exp en=1 we=1 d=12345678", ram_en1, ram_we1, ram_wdata1);
                end
            end
            n_cmp++;
            if (d_ack1 !== (c == 3)) begin
                n_bad++; $display("FAIL t6_d_ack c=%0d got=%b exp=%b", c, d_ack1, c == 3);
            end
            if (c >= 3) begin
                n_cmp++;
                if (d_rdata1 !== 32'h0) begin
                    n_bad++; $display("FAIL t6_d_rdata c=%0d got=%h exp=00000000", c, d_rdata1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_en;
        logic [31:0] exp_a;
        do_reset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            i_req = (c < 16); d_rd = (c < 16); d_wr = 1'b0;
            i_addr = 32'h40; d_addr = 32'h80;
            #1;
            exp_en = (c == 1 || c == 5 || c == 9 || c == 13);
            exp_a  = (c == 1 || c == 9) ? 32'h40 : 32'h80;
            n_cmp++;
            if (ram_en1 !== exp_en) begin
                n_bad++; $display("FAIL t7_ram_en c=%0d got=%b exp=%b", c, ram_en1, exp_en);
            end
            if (exp_en) begin
                n_cmp++;
                if (ram_addr1 !== exp_a) begin
                    n_bad++; $display("FAIL t7_ram_addr c=%0d got=%h exp=%h", c, ram_addr1, exp_a);
                end
            end
            n_cmp++;
            if (i_ack1 !== (c == 3 || c == 11) || d_ack1 !== (c == 7 || c == 15)) begin
                n_bad++; $display("FAIL t7_acks c=%0d got=%b%b exp=%b%b", c, i_ack1, d_ack1, c == 3 || c == 11, c == 7 || c == 15);
            end
            n_cmp++;
            if (stall1 !== (c < 16)) begin
                n_bad++; $display("FAIL t7_stall c=%0d got=%b exp=%b", c, stall1, c < 16);
            end
            if (c == 8) begin
                n_cmp++;
                if (d_rdata1 !== 32'h2008_00C5) begin
                    n_bad++; $display("FAIL t7_d_rdata got=%h exp=200800c5", d_rdata1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_lat1();
        test_tie_after_reset();
        test_write();
        test_lat4();
        test_reset_in_wait();
        test_rd_wr_both();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
